// File: rtl/deserializer_if.sv
// Chunk-in / word-out handshake bundle between a byte source, the deserializer
// and its wide-word consumer.
interface deserializer_if #(
    parameter int INWIDTH  = 8,
    parameter int OUTWIDTH = 256
);
    localparam int N  = OUTWIDTH / INWIDTH;
    localparam int LW = $clog2(N) + 1;

    logic [INWIDTH-1:0]  in_data;
    logic                in_valid;
    logic                in_last;
    logic                in_ready;
    logic [OUTWIDTH-1:0] out_data;
    logic [LW-1:0]       out_len;
    logic                out_last;
    logic                out_valid;
    logic                out_ready;

    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_len, out_last, out_valid
    );

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_len, out_last, out_valid
    );
endinterface

// File: rtl/deserializer.sv
// Packs an LSB-first chunk stream into one wide word plus a valid-chunk count.
//   state | meaning
//   FILL  | accepting chunks into the buffer, no word offered
//   HOLD  | word offered downstream, input stalled until taken
module deserializer #(
    parameter int INWIDTH  = 8,
    parameter int OUTWIDTH = 256
) (
    input  logic            clk_i,
    input  logic            reset_i,
    deserializer_if.slave   bus
);
    localparam int N  = OUTWIDTH / INWIDTH;
    localparam int LW = $clog2(N) + 1;

    typedef enum logic {FILL, HOLD} state_t;

    state_t              state_q, state_d;
    logic [LW-1:0]       count_q, count_d;
    logic [OUTWIDTH-1:0] buf_q,   buf_d;
    logic [LW-1:0]       len_q,   len_d;
    logic                last_q,  last_d;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= FILL;
            count_q <= '0;
            buf_q   <= '0;
            len_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            buf_q   <= buf_d;
            len_q   <= len_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        buf_d   = buf_q;
        len_d   = len_q;
        last_d  = last_q;
        unique case (state_q)
            FILL: begin
                if (bus.in_valid) begin
                    for (int i = 0; i < N; i++) begin
                        if (count_q == LW'(i)) buf_d[i*INWIDTH +: INWIDTH] = bus.in_data;
                    end
                    count_d = count_q + LW'(1);
                    // A full buffer closes the word even without in_last.
                    if (count_q == LW'(N-1) || bus.in_last) begin
                        state_d = HOLD;
                        len_d   = count_q + LW'(1);
                        last_d  = bus.in_last;
                    end
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_d = FILL;
                    count_d = '0;
                    buf_d   = '0;
                    len_d   = '0;
                    last_d  = 1'b0;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_q == FILL);
        bus.out_valid = (state_q == HOLD);
        bus.out_data  = buf_q;
        bus.out_len   = len_q;
        bus.out_last  = last_q;
    end
endmodule
